// File: rtl/mvu_pkg.sv
// Shared constants and helpers for the matrix-vector unit output drain.
package mvu_pkg;

  localparam int DEF_PE    = 4;
  localparam int DEF_TDSTI = 16;
  localparam int DEF_OPE   = 2;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_NF    = 8;

  // Counter width that stays at least one bit when the count range is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of output lane `lane` of beat `beat` inside a packed input vector.
  function automatic int lane_lsb(input int beat, input int lane, input int ope, input int w);
    return (beat * ope + lane) * w;
  endfunction

endpackage

// File: rtl/mvu_out_fifo.sv
// Synchronous FIFO holding whole accumulator vectors.
// The head entry is read combinationally from storage.
module mvu_out_fifo
  import mvu_pkg::*;
#(
  parameter int W     = DEF_PE * DEF_TDSTI,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr;
  logic          rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mvu_out_stream.sv
// Buffers completed PE accumulator vectors and streams them out as OPE-lane beats,
// flagging the final beat of every NF-vector frame with out_last.
module mvu_out_stream
  import mvu_pkg::*;
#(
  parameter int PE    = DEF_PE,
  parameter int TDstI = DEF_TDSTI,
  parameter int OPE   = DEF_OPE,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NF    = DEF_NF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_v,
  input  logic [PE*TDstI-1:0]   in_d,
  output logic                  in_rdy,
  output logic                  out_v,
  output logic [OPE*TDstI-1:0]  out_d,
  output logic                  out_last,
  input  logic                  out_rdy
);

  localparam int BEATS = PE / OPE;
  localparam int BW    = cnt_w(BEATS);
  localparam int VW    = cnt_w(NF);

  logic [PE*TDstI-1:0] head;
  logic                full;
  logic                empty;
  logic                rdy_reg;
  logic [BW-1:0]       beat_cnt;
  logic [VW-1:0]       vec_cnt;
  logic                push;
  logic                pop;
  logic                hs;
  logic                last_beat;

  mvu_out_fifo #(
    .W     (PE * TDstI),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_d),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Holds in_rdy low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_reg <= 1'b0;
    else        rdy_reg <= 1'b1;
  end

  assign in_rdy    = rdy_reg && !full;
  assign push      = in_v && in_rdy;
  assign out_v     = !empty;
  assign hs        = out_v && out_rdy;
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign pop       = hs && last_beat;
  assign out_last  = out_v && last_beat && (vec_cnt == VW'(NF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      vec_cnt  <= '0;
    end else if (hs) begin
      if (last_beat) begin
        beat_cnt <= '0;
        vec_cnt  <= (vec_cnt == VW'(NF - 1)) ? '0 : vec_cnt + 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < OPE; gi++) begin : g_lane
    assign out_d[gi*TDstI +: TDstI] =
      out_v ? head[lane_lsb(int'(beat_cnt), gi, OPE, TDstI) +: TDstI] : '0;
  end

  // A vector offered while in_rdy is low is dropped; flag it in simulation.
  always @(posedge clk) begin
    assert (!rst_n || !in_v || in_rdy)
      else $warning("mvu_out_stream: in_v asserted while in_rdy low, vector dropped");
  end

endmodule

// File: tb/tb_mvu_out_stream.sv
// Randomised and directed bench for mvu_out_stream against a queue-based stream model.
module tb_mvu_out_stream;

  localparam int PE    = 4;
  localparam int TDSTI = 8;
  localparam int OPE   = 2;
  localparam int DEPTH = 4;
  localparam int NF    = 3;
  localparam int BEATS = PE / OPE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_v;
  logic [31:0] in_d;
  logic        in_rdy;
  logic        out_v;
  logic [15:0] out_d;
  logic        out_last;
  logic        out_rdy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] acc_q[$];
  logic [16:0] cap_q[$];
  int          model_cnt;
  int          model_beat;

  always #5 clk = ~clk;

  mvu_out_stream #(
    .PE    (PE),
    .TDstI (TDSTI),
    .OPE   (OPE),
    .DEPTH (DEPTH),
    .NF    (NF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_v     (in_v),
    .in_d     (in_d),
    .in_rdy   (in_rdy),
    .out_v    (out_v),
    .out_d    (out_d),
    .out_last (out_last),
    .out_rdy  (out_rdy)
  );

  // Expected n-th accepted beat since reset: {out_last, data}.
  function automatic logic [16:0] exp_word(input int n);
    logic [31:0] v;
    int          b;
    int          k;
    v = acc_q[n / BEATS];
    b = n % BEATS;
    k = n / BEATS;
    return {(b == BEATS - 1) && (k % NF == NF - 1), v[b*16 +: 16]};
  endfunction

  // One clock cycle: drive, record accepted output beat mid-cycle, advance the model at the edge.
  task automatic tick(input logic v, input logic [31:0] d, input logic r);
    bit do_push;
    in_v = v; in_d = d; out_rdy = r;
    #4;
    if (out_v && r) cap_q.push_back({out_last, out_d});
    @(posedge clk);
    do_push = v && (model_cnt < DEPTH);
    if (model_cnt > 0 && r) begin
      if (model_beat == BEATS - 1) begin
        model_beat = 0;
        model_cnt--;
      end else begin
        model_beat++;
      end
    end
    if (do_push) begin
      acc_q.push_back(d);
      model_cnt++;
    end
    #1;
  endtask

  task automatic clear_model();
    acc_q.delete();
    cap_q.delete();
    model_cnt  = 0;
    model_beat = 0;
  endtask

  task automatic do_reset();
    in_v = 1'b0; out_rdy = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst_n = 1'b1;
    tick(1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && model_cnt > 0; i++) tick(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_v = 1'b0; in_d = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_v, out_last, in_rdy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got v/last/rdy=%b%b%b exp=000", out_v, out_last, in_rdy);
    end
    checks++;
    if (out_d !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0000", out_d);
    end
    clear_model();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_early got=%b exp=0", in_rdy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy_rise got=%b exp=1", in_rdy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    tick(1'b1, 32'h44332211, 1'b1);
    checks++;
    if (out_v !== 1'b1 || out_d !== 16'h2211 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL single_beat0 got v=%b d=%h l=%b exp v=1 d=2211 l=0", out_v, out_d, out_last);
    end
    tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_v !== 1'b1 || out_d !== 16'h4433 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL single_beat1 got v=%b d=%h l=%b exp v=1 d=4433 l=0", out_v, out_d, out_last);
    end
    tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_v !== 1'b0) begin
      failures++;
      $display("FAIL single_empty got v=%b exp v=0", out_v);
    end
    checks++;
    if (cap_q.size() != 2 || cap_q[0] !== exp_word(0) || cap_q[1] !== exp_word(1)) begin
      failures++;
      $display("FAIL single_stream got n=%0d exp n=2", cap_q.size());
    end
    $display("test_single beats=%0d", cap_q.size());
  endtask

  task automatic test_frame();
    int lasts;
    do_reset();
    for (int k = 0; k < 6; k++) tick(1'b1, $urandom, 1'b1);
    drain();
    checks++;
    if (cap_q.size() != acc_q.size() * BEATS) begin
      failures++;
      $display("FAIL frame_len got=%0d exp=%0d", cap_q.size(), acc_q.size() * BEATS);
    end
    lasts = 0;
    for (int n = 0; n < cap_q.size() && n < acc_q.size() * BEATS; n++) begin
      checks++;
      if (cap_q[n] !== exp_word(n)) begin
        failures++;
        $display("FAIL frame_beat%0d got=%h exp=%h", n, cap_q[n], exp_word(n));
      end
      if (cap_q[n][16]) lasts++;
    end
    checks++;
    if (lasts != 2) begin
      failures++;
      $display("FAIL frame_last_count got=%0d exp=2", lasts);
    end
    $display("test_frame vectors=%0d beats=%0d lasts=%0d", acc_q.size(), cap_q.size(), lasts);
  endtask

  task automatic test_backpressure();
    logic [31:0] v0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, (k == 0) ? 32'h44332211 : $urandom, 1'b0);
      v0 = acc_q[0];
      checks++;
      if (in_rdy !== (model_cnt < DEPTH)) begin
        failures++;
        $display("FAIL bp_rdy_after_push%0d got=%b exp=%b", k + 1, in_rdy, model_cnt < DEPTH);
      end
      checks++;
      if (out_v !== 1'b1 || out_d !== v0[15:0]) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=%h", k + 1, out_v, out_d, v0[15:0]);
      end
    end
    drain();
    checks++;
    if (cap_q.size() != 4 * BEATS) begin
      failures++;
      $display("FAIL bp_len got=%0d exp=%0d", cap_q.size(), 4 * BEATS);
    end
    for (int n = 0; n < cap_q.size() && n < acc_q.size() * BEATS; n++) begin
      checks++;
      if (cap_q[n] !== exp_word(n)) begin
        failures++;
        $display("FAIL bp_beat%0d got=%h exp=%h", n, cap_q[n], exp_word(n));
      end
    end
    $display("test_backpressure accepted=%0d beats=%0d", acc_q.size(), cap_q.size());
  endtask

  task automatic test_full_pop();
    logic [31:0] v1;
    do_reset();
    for (int k = 0; k < DEPTH; k++) tick(1'b1, $urandom, 1'b0);
    tick(1'b0, 32'h0, 1'b1);
    checks++;
    if (in_rdy !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_rdy_full got=%b exp=0", in_rdy);
    end
    tick(1'b1, 32'hDEADBEEF, 1'b1);
    v1 = acc_q[1];
    checks++;
    if (in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL fullpop_rdy_next got=%b exp=1", in_rdy);
    end
    checks++;
    if (out_d !== v1[15:0]) begin
      failures++;
      $display("FAIL fullpop_head got=%h exp=%h", out_d, v1[15:0]);
    end
    drain();
    checks++;
    if (cap_q.size() != DEPTH * BEATS) begin
      failures++;
      $display("FAIL fullpop_len got=%0d exp=%0d", cap_q.size(), DEPTH * BEATS);
    end
    for (int n = 0; n < cap_q.size() && n < acc_q.size() * BEATS; n++) begin
      checks++;
      if (cap_q[n] !== exp_word(n)) begin
        failures++;
        $display("FAIL fullpop_beat%0d got=%h exp=%h", n, cap_q[n], exp_word(n));
      end
    end
    $display("test_full_pop beats=%0d", cap_q.size());
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, $urandom, 1'b0);
    tick(1'b1, $urandom, 1'b0);
    checks++;
    if (out_v !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre_v got=%b exp=1", out_v);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_v, out_last, in_rdy} !== 3'b000 || out_d !== 16'h0) begin
      failures++;
      $display("FAIL mid_async got v/last/rdy=%b%b%b d=%h exp=000 d=0000", out_v, out_last, in_rdy, out_d);
    end
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst_n = 1'b1;
    tick(1'b0, 32'h0, 1'b0);
    checks++;
    if (in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL mid_rdy got=%b exp=1", in_rdy);
    end
    for (int k = 0; k < NF; k++) tick(1'b1, $urandom, 1'b1);
    drain();
    checks++;
    if (cap_q.size() != NF * BEATS) begin
      failures++;
      $display("FAIL mid_len got=%0d exp=%0d", cap_q.size(), NF * BEATS);
    end
    for (int n = 0; n < cap_q.size() && n < acc_q.size() * BEATS; n++) begin
      checks++;
      if (cap_q[n] !== exp_word(n)) begin
        failures++;
        $display("FAIL mid_beat%0d got=%h exp=%h", n, cap_q[n], exp_word(n));
      end
    end
    $display("test_reset_mid beats=%0d", cap_q.size());
  endtask

  task automatic test_random();
    logic v;
    logic r;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      checks++;
      if (in_rdy !== (model_cnt < DEPTH) || out_v !== (model_cnt > 0)) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d got rdy=%b v=%b exp rdy=%b v=%b",
                 c, in_rdy, out_v, model_cnt < DEPTH, model_cnt > 0);
      end
      r = ($urandom % 4) != 0;
      v = ($urandom % 2 == 1) && (model_cnt < DEPTH);
      tick(v, $urandom, r);
    end
    drain();
    checks++;
    if (cap_q.size() != acc_q.size() * BEATS) begin
      failures++;
      $display("FAIL rand_len got=%0d exp=%0d", cap_q.size(), acc_q.size() * BEATS);
    end
    for (int n = 0; n < cap_q.size() && n < acc_q.size() * BEATS; n++) begin
      checks++;
      if (cap_q[n] !== exp_word(n)) begin
        failures++;
        $display("FAIL rand_beat%0d got=%h exp=%h", n, cap_q[n], exp_word(n));
      end
    end
    $display("test_random vectors=%0d beats=%0d", acc_q.size(), cap_q.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
